guess_arbiter: RTL and testbench

Multi-player front end for the hangman game-logic core. Collects letter guesses from up to four player requesters, arbitrates round-robin, validates and normalises each letter, filters repeats, and presents one guess at a time on the game core's `guess` input. A new guess is issued only while the core is ready, and the arbiter waits for the core to complete its letter scan. Sits between the player input/receiver blocks and the game-logic core.

---
 rtl/hangman_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/guess_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_guess_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared types and ASCII constants for the hangman front end.
package hangman_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_BUSY,
        WAIT_RDY,
        HALT
    } arb_state_t;

    localparam logic [7:0] ASCII_UA    = 8'h41;
    localparam logic [7:0] ASCII_UZ    = 8'h5A;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LZ    = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    localparam int MAX_PLAYERS = 4;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= ASCII_LA && c <= ASCII_LZ) ? c - CASE_OFFSET : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_PLAYERS = 2
) (
    input  logic [NUM_PLAYERS-1:0] req,
    input  logic [1:0]             ptr,
    output logic [NUM_PLAYERS-1:0] grant,
    output logic [1:0]             idx,
    output logic                   any
);

    logic [2:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cand = {1'b0, ptr} + 3'(i);
            if (cand >= 3'(NUM_PLAYERS)) begin
                cand = cand - 3'(NUM_PLAYERS);
            end
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (!any && cand == 3'(j) && req[j]) begin
                    grant[j] = 1'b1;
                    idx      = cand[1:0];
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/guess_arbiter.sv
// Multi-player guess arbiter in front of the hangman core.
// Optional repeat filtering is enabled by defining GUESS_DUP_FILTER_EN.
module guess_arbiter
    import hangman_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TIMEOUT     = 8
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic [NUM_PLAYERS-1:0]   req,
    input  logic [8*NUM_PLAYERS-1:0] letter_in,
    output logic [NUM_PLAYERS-1:0]   ack,
    output logic [NUM_PLAYERS-1:0]   nack,
    input  logic                     game_rdy,
    input  logic                     game_over,
    input  logic                     new_game,
    output logic [7:0]               guess,
    output logic                     guess_valid,
    output logic [1:0]               active_player,
    output logic                     busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    arb_state_t             state_q, state_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [1:0]             gidx_q, gidx_d;
    logic [7:0]             letter_q, letter_d;
    logic [7:0]             guess_q, guess_d;
    logic [1:0]             active_q, active_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [NUM_PLAYERS-1:0] ack_q, ack_d;
    logic [NUM_PLAYERS-1:0] nack_q, nack_d;
    logic                   gv_q, gv_d;
    logic                   busy_q, busy_d;
`ifdef GUESS_DUP_FILTER_EN
    logic [25:0]            mask_q, mask_d;
    logic [4:0]             mask_off;
`endif

    logic [NUM_PLAYERS-1:0] arb_grant;
    logic [1:0]             arb_idx;
    logic                   arb_any;
    logic [7:0]             letter_sel;
    logic [7:0]             norm;
    logic                   letter_ok;
    logic [NUM_PLAYERS-1:0] gnt_oh;
    logic [2:0]             ptr_sum;
    logic [1:0]             ptr_inc;

    rr_arbiter #(.NUM_PLAYERS(NUM_PLAYERS)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        letter_sel = '0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (arb_grant[j]) begin
                letter_sel = letter_in[8*j +: 8];
            end
        end
    end

    // Validation works on the letter latched at grant time, so later input changes are ignored.
    always_comb begin
        norm = to_upper(letter_q);
`ifdef GUESS_DUP_FILTER_EN
        mask_off  = 5'(norm - ASCII_UA);
        letter_ok = (norm >= ASCII_UA) && (norm <= ASCII_UZ) && !mask_q[mask_off];
`else
        letter_ok = (norm >= ASCII_UA) && (norm <= ASCII_UZ);
`endif
        gnt_oh  = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << gidx_q;
        ptr_sum = {1'b0, gidx_q} + 3'd1;
        ptr_inc = (ptr_sum >= 3'(NUM_PLAYERS)) ? 2'd0 : ptr_sum[1:0];
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        letter_d = letter_q;
        guess_d  = guess_q;
        active_d = active_q;
        tmo_d    = tmo_q;
        ack_d    = '0;
        nack_d   = '0;
        gv_d     = 1'b0;
`ifdef GUESS_DUP_FILTER_EN
        mask_d   = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (game_over) begin
                    state_d = HALT;
                end else if (arb_any && game_rdy) begin
                    gidx_d   = arb_idx;
                    active_d = arb_idx;
                    letter_d = letter_sel;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                ptr_d = ptr_inc;
                if (letter_ok) begin
                    ack_d   = gnt_oh;
                    guess_d = norm;
                    gv_d    = 1'b1;
                    tmo_d   = '0;
`ifdef GUESS_DUP_FILTER_EN
                    mask_d  = mask_q | (26'd1 << mask_off);
`endif
                    state_d = WAIT_BUSY;
                end else begin
                    nack_d  = gnt_oh;
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (!game_rdy) begin
                    tmo_d   = '0;
                    state_d = WAIT_RDY;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_RDY: begin
                if (game_rdy) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                nack_d = req;
            end
            default: state_d = IDLE;
        endcase

        // A fresh round overrides whatever the FSM decided this cycle.
        if (new_game) begin
            state_d  = IDLE;
            ptr_d    = '0;
            guess_d  = '0;
            active_d = '0;
            tmo_d    = '0;
            ack_d    = '0;
            nack_d   = '0;
            gv_d     = 1'b0;
`ifdef GUESS_DUP_FILTER_EN
            mask_d   = '0;
`endif
        end

        busy_d = (state_d != IDLE) && (state_d != HALT);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            letter_q <= '0;
            guess_q  <= '0;
            active_q <= '0;
            tmo_q    <= '0;
            ack_q    <= '0;
            nack_q   <= '0;
            gv_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef GUESS_DUP_FILTER_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            letter_q <= letter_d;
            guess_q  <= guess_d;
            active_q <= active_d;
            tmo_q    <= tmo_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            gv_q     <= gv_d;
            busy_q   <= busy_d;
`ifdef GUESS_DUP_FILTER_EN
            mask_q   <= mask_d;
`endif
        end
    end

    assign ack           = ack_q;
    assign nack          = nack_q;
    assign guess         = guess_q;
    assign guess_valid   = gv_q;
    assign active_player = active_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_guess_arbiter.sv
// Scoreboard bench for guess_arbiter with a simple ready/busy core model.
module tb_guess_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           nRst;
    logic [N-1:0]   req;
    logic [8*N-1:0] letter_in;
    logic [N-1:0]   ack;
    logic [N-1:0]   nack;
    logic           game_rdy;
    logic           game_over;
    logic           new_game;
    logic [7:0]     guess;
    logic           guess_valid;
    logic [1:0]     active_player;
    logic           busy;

    guess_arbiter #(.NUM_PLAYERS(N), .TIMEOUT(8)) dut (
        .clk           (clk),
        .nRst          (nRst),
        .req           (req),
        .letter_in     (letter_in),
        .ack           (ack),
        .nack          (nack),
        .game_rdy      (game_rdy),
        .game_over     (game_over),
        .new_game      (new_game),
        .guess         (guess),
        .guess_valid   (guess_valid),
        .active_player (active_player),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p;
        bit         ok;
        logic [7:0] g;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] tb_guess = 8'h00;
    int         tb_ptr   = 0;
    bit         mon_en   = 1'b0;
    bit         core_en  = 1'b1;
`ifdef GUESS_DUP_FILTER_EN
    localparam bit DUP_OK = 1'b0;
`else
    localparam bit DUP_OK = 1'b1;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] norm_c(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    task automatic push_exp(input int p, input logic [7:0] c, input bit ok);
        exp_t e;
        e.p  = p;
        e.ok = ok;
        if (ok) tb_guess = norm_c(c);
        e.g  = tb_guess;
        sbq.push_back(e);
        tb_ptr = (p + 1) % N;
    endtask

    // Core model: goes busy for three cycles after each issued guess.
    initial begin
        forever begin
            @(negedge clk);
            if (guess_valid && core_en) begin
                game_rdy = 1'b0;
                repeat (3) @(negedge clk);
                game_rdy = 1'b1;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (|ack || |nack)) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected", {30'd0, ack}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_ack",   {30'd0, ack},  e.ok ? (32'd1 << e.p) : 32'd0);
                    chk("sb_nack",  {30'd0, nack}, e.ok ? 32'd0 : (32'd1 << e.p));
                    chk("sb_guess", {24'd0, guess}, {24'd0, e.g});
                    chk("sb_gv",    {31'd0, guess_valid}, {31'd0, e.ok});
                    chk("sb_active", {30'd0, active_player}, e.p);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            if (!busy && game_rdy) break;
            @(negedge clk);
        end
        if (k == 60) chk("idle_wait", 32'd0, 32'd1);
    endtask

    task automatic issue(input int p, input logic [7:0] c, input bit ok);
        int n;
        bit done;
        wait_idle();
        letter_in[8*p +: 8] = c;
        req[p] = 1'b1;
        push_exp(p, c, ok);
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (ack[p] || nack[p]) done = 1'b1;
        end
        chk("latency", n, 32'd2);
        chk("busy_at_resp", {31'd0, busy}, {31'd0, ok});
        req[p] = 1'b0;
    endtask

    task automatic pair(input logic [7:0] c0, input logic [7:0] c1);
        int first;
        int served;
        wait_idle();
        letter_in[7:0]  = c0;
        letter_in[15:8] = c1;
        req = 2'b11;
        first = tb_ptr;
        push_exp(first, first == 0 ? c0 : c1, 1'b1);
        push_exp(1 - first, first == 0 ? c1 : c0, 1'b1);
        served = 0;
        for (int k = 0; k < 80 && served < 2; k++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) begin
                if (req[j] && (ack[j] || nack[j])) begin
                    req[j] = 1'b0;
                    served++;
                end
            end
        end
        chk("pair_served", served, 32'd2);
    endtask

    initial begin
        int cnt;
        nRst      = 1'b0;
        req       = '0;
        letter_in = '0;
        game_rdy  = 1'b1;
        game_over = 1'b0;
        new_game  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_guess",  {24'd0, guess}, 32'd0);
        chk("rst_ack",    {30'd0, ack}, 32'd0);
        chk("rst_nack",   {30'd0, nack}, 32'd0);
        chk("rst_gv",     {31'd0, guess_valid}, 32'd0);
        chk("rst_active", {30'd0, active_player}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        nRst   = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // lowercase 'a' from player 0
        issue(0, 8'h61, 1'b1);
        @(negedge clk);
        chk("gv_once", {31'd0, guess_valid}, 32'd0);
        chk("busy_mid", {31'd0, busy}, 32'd1);

        pair(8'h62, 8'h63);
        pair(8'h64, 8'h66);

        // non-letter gets rejected and leaves guess untouched
        issue(1, 8'h31, 1'b0);
        issue(0, 8'h40, 1'b0);
        issue(1, 8'h5B, 1'b0);
        issue(0, 8'h7A, 1'b1);

        issue(0, 8'h45, 1'b1);
        issue(1, 8'h45, DUP_OK);

        // core never goes busy: arbiter should give up after the timeout
        core_en = 1'b0;
        issue(0, 8'h78, 1'b1);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("timeout_cycles", cnt, 32'd7);
        core_en = 1'b1;
        issue(1, 8'h79, 1'b1);

        // game over and a request in the same idle cycle
        wait_idle();
        mon_en = 1'b0;
        game_over = 1'b1;
        letter_in[7:0] = 8'h67;
        req[0] = 1'b1;
        @(negedge clk);
        chk("halt_no_ack",  {30'd0, ack}, 32'd0);
        chk("halt_no_nack0", {30'd0, nack}, 32'd0);
        chk("halt_busy",    {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_nack", {30'd0, nack}, 32'd1);
            chk("halt_gv",   {31'd0, guess_valid}, 32'd0);
        end
        new_game  = 1'b1;
        req       = '0;
        game_over = 1'b0;
        @(negedge clk);
        chk("ng_nack",   {30'd0, nack}, 32'd0);
        chk("ng_guess",  {24'd0, guess}, 32'd0);
        chk("ng_active", {30'd0, active_player}, 32'd0);
        chk("ng_busy",   {31'd0, busy}, 32'd0);
        new_game = 1'b0;
        tb_guess = 8'h00;
        tb_ptr   = 0;
        mon_en   = 1'b1;
        @(negedge clk);

        issue(0, 8'h45, 1'b1);
        issue(1, 8'h65, DUP_OK);

        repeat (10) @(negedge clk);
        chk("sb_left", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
